pr_hrav_rr_dispatch: RTL

PR_HRAV_RR_DISPATCH -- requirements
Module: pr_hrav_rr_dispatch

---
 rtl/pr_hrav_pkg.sv | 18 +
 rtl/pr_hrav_rr_arb.sv | 33 +++
 rtl/pr_hrav_rr_dispatch.sv | 106 ++++++++++
 3 files changed

// File: rtl/pr_hrav_pkg.sv
// Shared dispatcher definitions: FSM encoding and
// the round-robin pointer increment helper.
package pr_hrav_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    function automatic logic [4:0] ptr_inc(
        input logic [4:0]  p,
        input int unsigned n
    );
        logic [4:0] nx;
        nx = p + 5'd1;
        if (32'(nx) >= n) nx = '0;
        return nx;
    endfunction

endpackage

// File: rtl/pr_hrav_rr_arb.sv
// Round-robin first-enabled search: lowest set mask bit
// at or above ptr, wrapping modulo N.
module pr_hrav_rr_arb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     sum;

    always_comb begin
        dbl   = {mask, mask} >> ptr;
        rot   = dbl[N-1:0];
        any   = 1'b0;
        sum   = '0;
        // descending scan so the nearest bit to ptr wins
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + (W + 1)'(i);
                any = 1'b1;
            end
        end
        if (sum >= (W + 1)'(N)) sum = sum - (W + 1)'(N);
        grant = sum[W-1:0];
    end

endmodule

// File: rtl/pr_hrav_rr_dispatch.sv
// Packet-atomic round-robin dispatcher onto a shared
// data bus with a one-beat output register.
module pr_hrav_rr_dispatch
    import pr_hrav_pkg::*;
#(
    parameter int DAT_BW = 128,
    parameter int NUM_PE = 4,
    parameter int PE_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_in,
    input  logic [DAT_BW-1:0] data_in,
    input  logic              eop_in,
    output logic              ready_out,
    input  logic [NUM_PE-1:0] pe_en,
    input  logic [NUM_PE-1:0] ready_in,
    output logic [NUM_PE-1:0] vld_out,
    output logic [DAT_BW-1:0] data_out,
    output logic              eop_out,
    output logic [31:0]       pkt_cnt
);

    logic [0:0]        state_q, state_d;
    logic [PE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PE_W-1:0]   cur_pe_q, cur_pe_d;
    logic              vld_q, vld_d;
    logic [DAT_BW-1:0] data_q, data_d;
    logic              eop_q, eop_d;
    logic [PE_W-1:0]   dst_q, dst_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;

    logic [PE_W-1:0]   grant;
    logic              any;
    logic              drain;
    logic              acc;

    pr_hrav_rr_arb #(
        .N (NUM_PE),
        .W (PE_W)
    ) u_arb (
        .mask  (pe_en),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .any   (any)
    );

    assign drain     = vld_q & ready_in[dst_q];
    assign ready_out = (state_q == ST_LOCK) & (~vld_q | ready_in[dst_q]);
    assign acc       = vld_in & ready_out;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_pe_d  = cur_pe_q;
        data_d    = data_q;
        eop_d     = eop_q;
        dst_d     = dst_q;
        pkt_cnt_d = pkt_cnt_q;
        vld_d     = drain ? 1'b0 : vld_q;
        if (state_q == ST_IDLE) begin
            if (vld_in && any) begin
                cur_pe_d = grant;
                state_d  = ST_LOCK;
            end
        end else if (acc) begin
            vld_d  = 1'b1;
            data_d = data_in;
            eop_d  = eop_in;
            dst_d  = cur_pe_q;
            if (eop_in) begin
                state_d   = ST_IDLE;
                rr_ptr_d  = PE_W'(ptr_inc(5'(cur_pe_q), NUM_PE));
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            cur_pe_q  <= '0;
            vld_q     <= 1'b0;
            data_q    <= '0;
            eop_q     <= 1'b0;
            dst_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_pe_q  <= cur_pe_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
            eop_q     <= eop_d;
            dst_q     <= dst_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign vld_out  = vld_q ? (NUM_PE'(1) << dst_q) : '0;
    assign data_out = data_q;
    assign eop_out  = eop_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule
